fp_alu_result_fifo: RTL

Elastic output stage directly downstream of the combinational floating-point ALU (add/multiply, W-bit result plus overflow flag). Captures each ALU result together with its overflow flag and operation select into a small first-word-fall-through FIFO with valid/ready handshakes on both sides. Maintains a sticky overflow status and a saturating overflow counter for software visibility. Decouples the ALU from a stalling consumer.

---
 rtl/fp_alu_pkg.sv | 16 +
 rtl/fp_fifo_mem.sv | 22 ++
 rtl/fp_alu_result_fifo.sv | 84 ++++++++
 3 files changed

// File: rtl/fp_alu_pkg.sv
// Definitions shared by the floating-point ALU wrapper and its result stage.
// An entry is packed as {sel, overflow, result}.
package fp_alu_pkg;
  localparam int FP_W       = 32;
  localparam logic OP_ADD   = 1'b0;
  localparam logic OP_MUL   = 1'b1;
  localparam int FP_ENTRY_W = FP_W + 2;
  localparam int FP_OVF_BIT = FP_W;
  localparam int FP_SEL_BIT = FP_W + 1;

  typedef struct packed {
    logic            sel;
    logic            overflow;
    logic [FP_W-1:0] result;
  } fp_entry_t;
endpackage

// File: rtl/fp_fifo_mem.sv
// Register array used as FIFO storage: synchronous write and asynchronous read.
// The storage has no reset because the top forces its outputs to zero while the FIFO is empty.
module fp_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fp_alu_result_fifo.sv
// First-word-fall-through output FIFO for ALU results. It also keeps a sticky overflow flag
// and a saturating overflow counter.
module fp_alu_result_fifo
  import fp_alu_pkg::*;
#(
  parameter int W      = FP_W,
  parameter int DEPTH  = 4,
  parameter int OVF_CW = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               in_result,
  input  logic                       in_overflow,
  input  logic                       in_sel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_result,
  output logic                       out_overflow,
  output logic                       out_sel,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf_sticky,
  input  logic                       ovf_clear,
  output logic [OVF_CW-1:0]          ovf_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = W + 2;
  localparam logic [OVF_CW-1:0] OVF_MAX = {OVF_CW{1'b1}};

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [EW-1:0] rd_entry;
  logic          full, empty, push, pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  fp_fifo_mem #(.DEPTH(DEPTH), .WIDTH(EW), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({in_sel, in_overflow, in_result}),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  // The head is presented only while it is valid, so stale storage never leaks out.
  assign out_result   = empty ? '0   : rd_entry[W-1:0];
  assign out_overflow = empty ? 1'b0 : rd_entry[W];
  assign out_sel      = empty ? 1'b0 : rd_entry[W+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // When a clear and an overflow push happen in the same cycle, the new overflow is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (push && in_overflow) begin
      ovf_sticky <= 1'b1;
      if (ovf_clear)                ovf_count <= OVF_CW'(1);
      else if (ovf_count != OVF_MAX) ovf_count <= ovf_count + OVF_CW'(1);
    end else if (ovf_clear) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end
  end
endmodule
